layer_sequencer: RTL and testbench

- Top-level controller that steps one cnn_layer instance through every network layer in order.
- Drives cs_layer and a one-cycle load pulse to the layer and waits for its valid.
- Captures each layer's output into an internal feature register and feeds it back as the next layer's input.
- After the last (affine) layer, presents the final feature vector and pulses done.

---
 rtl/layer_sequencer.sv | 120 ++++++++++++
 tb/tb_layer_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps one cnn_layer through every network layer and returns the affine result.
// Ports: clk_i/rst_ni (sync, active-low) clock and reset; start_i/d_in_i start an inference on an image;
// layer_valid_i/layer_q_i are the cnn_layer finish level and result; load_o/cs_layer_o/layer_d_o drive
// cnn_layer; busy_o, done_o, error_o report status; q_o holds the final affine feature vector.
// Optional macro LAYER_SEQ_WATCHDOG_EN adds a WAIT timeout of TIMEOUT cycles that raises error_o.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif
`ifndef AFFINE
`define AFFINE 4
`endif
module layer_sequencer #(
  parameter int NUM_LAYERS = `AFFINE,
  parameter int FW = 384*`DATA_LEN,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [FW-1:0] d_in_i,
  input  logic          layer_valid_i,
  input  logic [FW-1:0] layer_q_i,
  output logic          load_o,
  output logic [3:0]    cs_layer_o,
  output logic [FW-1:0] layer_d_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [FW-1:0] q_o
);
  typedef enum logic [2:0] {IDLE, LOAD, ARM, WAIT, NEXT, DONE} state_e;
  localparam logic [3:0] LAST = 4'(NUM_LAYERS);
  state_e state_q;
  logic load_q, busy_q, done_q;
  logic [3:0] cs_q, idx_q;
  logic [FW-1:0] feat_q, res_q;
`ifdef LAYER_SEQ_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic error_q;
  logic [15:0] wd_q;
  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif
  assign load_o = load_q;
  assign cs_layer_o = cs_q;
  assign layer_d_o = feat_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign q_o = res_q;
  // Outputs are registered alongside the state so they always describe the state being entered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      load_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cs_q <= '0;
      idx_q <= '0;
      feat_q <= '0;
      res_q <= '0;
`ifdef LAYER_SEQ_WATCHDOG_EN
      error_q <= 1'b0;
      wd_q <= '0;
`endif
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          feat_q <= d_in_i;
          idx_q <= 4'd1;
          cs_q <= 4'd1;
          load_q <= 1'b1;
          busy_q <= 1'b1;
          state_q <= LOAD;
`ifdef LAYER_SEQ_WATCHDOG_EN
          error_q <= 1'b0;
`endif
        end
        LOAD: state_q <= ARM;
        // A valid still high from the previous layer is deliberately ignored here.
        ARM: begin
          state_q <= WAIT;
`ifdef LAYER_SEQ_WATCHDOG_EN
          wd_q <= '0;
`endif
        end
        WAIT: if (layer_valid_i) begin
          feat_q <= layer_q_i;
          state_q <= NEXT;
        end
`ifdef LAYER_SEQ_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          error_q <= 1'b1;
          busy_q <= 1'b0;
          cs_q <= '0;
          state_q <= IDLE;
        end else wd_q <= wd_q + 16'd1;
`endif
        NEXT: if (idx_q == LAST) begin
          res_q <= feat_q;
          done_q <= 1'b1;
          cs_q <= '0;
          state_q <= DONE;
        end else begin
          idx_q <= idx_q + 4'd1;
          cs_q <= idx_q + 4'd1;
          load_q <= 1'b1;
          state_q <= LOAD;
        end
        DONE: begin
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized self-checking bench for layer_sequencer with a cnn_layer stub.
module tb_layer_sequencer;
  localparam int N = 4;
  logic clk = 0, rst_n = 0, start = 0, lv = 0;
  logic [63:0] d_in = '0, lq = '0, layer_d, q;
  logic load, busy, done, error;
  logic [3:0] cs_layer;
  logic start1 = 0, load1, busy1, done1, err1;
  logic [63:0] lq1 = '0, ld1, q1;
  logic [3:0] cs1;
  logic stk = 0, never = 0;
  int cnt = 0;
  int dly_q[$];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  layer_sequencer #(.NUM_LAYERS(N), .FW(64), .TIMEOUT(20)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .d_in_i(d_in), .layer_valid_i(lv),
    .layer_q_i(lq), .load_o(load), .cs_layer_o(cs_layer), .layer_d_o(layer_d), .busy_o(busy),
    .done_o(done), .error_o(error), .q_o(q));
  layer_sequencer #(.NUM_LAYERS(1), .FW(64), .TIMEOUT(20)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .d_in_i(64'h0123_4567_89ab_cdef), .layer_valid_i(1'b1),
    .layer_q_i(lq1), .load_o(load1), .cs_layer_o(cs1), .layer_d_o(ld1), .busy_o(busy1),
    .done_o(done1), .error_o(err1), .q_o(q1));
  function automatic logic [63:0] lf(input logic [63:0] d, input logic [3:0] cs);
    return {d[55:0], d[63:56]} ^ {8{cs, ~cs}};
  endfunction
  // cnn_layer stub: result computed at load, valid rises after the bench-chosen compute time.
  always @(posedge clk) begin
    if (!rst_n) begin
      lv <= 1'b0;
      cnt <= 0;
    end else if (load) begin
      lq <= lf(layer_d, cs_layer);
      lv <= stk && !never;
      cnt <= (stk || never) ? 0 : dly_q.pop_front() + 1;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      lv <= (cnt == 1);
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Runs one inference from the current negedge; returns at the negedge inside the DONE cycle.
  task automatic run(input logic [63:0] d, input bit sticky, input bit mid);
    logic [63:0] e, prev_q;
    int loads, lat, explat;
    bit got;
    prev_q = q;
    stk = sticky;
    dly_q.delete();
    explat = 1;
    for (int i = 0; i < N; i++) begin
      int c;
      c = $urandom_range(0, 6);
      dly_q.push_back(c);
      explat += 4 + (sticky ? 0 : c);
    end
    start = 1;
    d_in = d;
    @(negedge clk);
    start = 0;
    d_in = {$urandom, $urandom};
    e = d;
    loads = 0;
    got = 0;
    lat = 0;
    for (int t = 1; t <= 400 && !got; t++) begin
      start = 0;
      if (load) begin
        loads++;
        chk("cs_layer", 64'(cs_layer), 64'(loads));
        chk("layer_d", layer_d, e);
        e = lf(e, 4'(loads));
        if (mid && loads == 2) start = 1;
      end
      if (t == 2) begin
        chk("q_hold", q, prev_q);
        chk("busy", 64'(busy), 64'd1);
        chk("error_clr", 64'(error), 64'd0);
      end
      if (done) begin
        got = 1;
        lat = t;
      end else @(negedge clk);
    end
    start = 0;
    chk("done_seen", 64'(got), 64'd1);
    chk("loads", 64'(loads), 64'(N));
    chk("latency", 64'(lat), 64'(explat));
    chk("q", q, e);
  endtask
  initial begin
    logic [63:0] pq;
    int loads;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_cs", 64'(cs_layer), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(error), 64'd0);
    chk("rst_feat", layer_d, 64'd0);
    chk("rst_q", q, 64'd0);
    rst_n = 1;
    @(negedge clk);
    run({$urandom, $urandom}, 0, 0);
    start = 1;
    d_in = {$urandom, $urandom};
    @(negedge clk);
    chk("done_start_ignored", 64'(busy), 64'd0);
    run({$urandom, $urandom}, 0, 0);
    @(negedge clk);
    run({$urandom, $urandom}, 1, 0);
    @(negedge clk);
    run({$urandom, $urandom}, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("no_restart", 64'(busy), 64'd0);
    stk = 0;
    dly_q.delete();
    repeat (N) dly_q.push_back($urandom_range(0, 6));
    start = 1;
    d_in = {$urandom, $urandom};
    @(negedge clk);
    start = 0;
    loads = 0;
    for (int t = 0; t < 200 && loads < 3; t++) begin
      if (load) loads++;
      if (loads < 3) @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_load", 64'(load), 64'd0);
    chk("mid_rst_cs", 64'(cs_layer), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_err", 64'(error), 64'd0);
    chk("mid_rst_feat", layer_d, 64'd0);
    chk("mid_rst_q", q, 64'd0);
    rst_n = 1;
    @(negedge clk);
    run({$urandom, $urandom}, 0, 0);
    repeat (3) begin
      @(negedge clk);
      run({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
`ifdef LAYER_SEQ_WATCHDOG_EN
    @(negedge clk);
    never = 1;
    pq = q;
    seen = 0;
    start = 1;
    d_in = {$urandom, $urandom};
    @(negedge clk);
    start = 0;
    for (int t = 1; t <= 30; t++) begin
      if (done) seen = 1;
      if (t == 22) begin
        chk("wd_pre_err", 64'(error), 64'd0);
        chk("wd_pre_busy", 64'(busy), 64'd1);
      end
      if (t == 23) begin
        chk("wd_err", 64'(error), 64'd1);
        chk("wd_busy", 64'(busy), 64'd0);
        chk("wd_q", q, pq);
      end
      @(negedge clk);
    end
    chk("wd_no_done", 64'(seen), 64'd0);
    chk("wd_err_held", 64'(error), 64'd1);
    never = 0;
    run({$urandom, $urandom}, 0, 0);
`endif
    @(negedge clk);
    lq1 = {$urandom, $urandom};
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    loads = 0;
    seen = 0;
    for (int t = 1; t <= 20 && !seen; t++) begin
      if (load1) begin
        loads++;
        chk("n1_cs", 64'(cs1), 64'd1);
      end
      if (done1) begin
        seen = 1;
        chk("n1_latency", 64'(t), 64'd5);
      end else @(negedge clk);
    end
    chk("n1_done", 64'(seen), 64'd1);
    chk("n1_loads", 64'(loads), 64'd1);
    chk("n1_q", q1, lq1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
